// File: rtl/mem_arb_pkg.sv
// Shared types and grant encodings for the memory-port arbiter.
// Optional macro ARB_RR_EN (round-robin tie-break) is consumed by the arbiter files.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  localparam logic GNT_D = 1'b0;
  localparam logic GNT_I = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational next-grant selector for the memory-port arbiter.
// Defining ARB_RR_EN turns the D-over-I fixed priority into an alternating tie-break.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_reqD,
  input  logic i_reqI,
  input  logic i_lastGrant,
  output logic o_pick,
  output logic o_valid
);

  assign o_valid = i_reqD | i_reqI;

`ifdef ARB_RR_EN
  always_comb begin
    o_pick = GNT_D;
    if (i_reqD && i_reqI) begin
      // On a tie, hand the port to whoever did not finish last.
      o_pick = (i_lastGrant == GNT_D) ? GNT_I : GNT_D;
    end else if (i_reqI) begin
      o_pick = GNT_I;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_lastGrant;
  assign o_pick = i_reqD ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (data D, instruction-fetch I) arbiter for the single cache/SRAM port.
// Define ARB_RR_EN for round-robin arbitration on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dRdEnIn,
  input  logic              dWrEnIn,
  input  logic [ADDR_W-1:0] dAdrIn,
  input  logic [DATA_W-1:0] dWDataIn,
  output logic [DATA_W-1:0] dRDataOut,
  output logic              dReadyOut,
  input  logic              iRdEnIn,
  input  logic [ADDR_W-1:0] iAdrIn,
  output logic [DATA_W-1:0] iRDataOut,
  output logic              iReadyOut,
  output logic              dsRdEnOut,
  output logic              dsWrEnOut,
  output logic [ADDR_W-1:0] dsAdrOut,
  output logic [DATA_W-1:0] dsWDataOut,
  input  logic [DATA_W-1:0] dsRDataIn,
  input  logic              dsReadyIn
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_req_d;
  logic   w_req_i;
  logic   w_pick;
  logic   w_pick_vld;
  logic   w_last_grant;

  assign w_req_d = dRdEnIn | dWrEnIn;
  assign w_req_i = iRdEnIn;

`ifdef ARB_RR_EN
  logic r_last_grant;

  // Reset to I so that D wins the very first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= GNT_I;
    end else if (dsReadyIn) begin
      if (r_state == BUSY_D) begin
        r_last_grant <= GNT_D;
      end else if (r_state == BUSY_I) begin
        r_last_grant <= GNT_I;
      end
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GNT_I;
`endif

  arb_pick u_pick (
    .i_reqD     (w_req_d),
    .i_reqI     (w_req_i),
    .i_lastGrant(w_last_grant),
    .o_pick     (w_pick),
    .o_valid    (w_pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    dsRdEnOut   = 1'b0;
    dsWrEnOut   = 1'b0;
    dsAdrOut    = '0;
    dsWDataOut  = '0;
    dRDataOut   = '0;
    iRDataOut   = '0;
    dReadyOut   = ~w_req_d;
    iReadyOut   = ~w_req_i;

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = (w_pick == GNT_D) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_D: begin
        if (dsReadyIn) begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_I: begin
        if (dsReadyIn) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are gated by rst directly so an abandoned access drops at once.
    if (rst) begin
      case (r_state)
        BUSY_D: begin
          dsWrEnOut  = dWrEnIn;
          dsRdEnOut  = dRdEnIn & ~dWrEnIn;
          dsAdrOut   = dAdrIn;
          dsWDataOut = dWDataIn;
          dRDataOut  = dsRDataIn;
          dReadyOut  = ~w_req_d | dsReadyIn;
        end
        BUSY_I: begin
          dsRdEnOut  = iRdEnIn;
          dsAdrOut   = iAdrIn;
          iRDataOut  = dsRDataIn;
          iReadyOut  = ~w_req_i | dsReadyIn;
        end
        default: ;
      endcase
    end else begin
      dReadyOut = 1'b1;
      iReadyOut = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (default and ARB_RR_EN builds).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          dRdEnIn, dWrEnIn, iRdEnIn, dsReadyIn;
  logic [AW-1:0] dAdrIn, iAdrIn, dsAdrOut;
  logic [DW-1:0] dWDataIn, dRDataOut, iRDataOut, dsWDataOut, dsRDataIn;
  logic          dReadyOut, iReadyOut, dsRdEnOut, dsWrEnOut;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .dRdEnIn   (dRdEnIn),
    .dWrEnIn   (dWrEnIn),
    .dAdrIn    (dAdrIn),
    .dWDataIn  (dWDataIn),
    .dRDataOut (dRDataOut),
    .dReadyOut (dReadyOut),
    .iRdEnIn   (iRdEnIn),
    .iAdrIn    (iAdrIn),
    .iRDataOut (iRDataOut),
    .iReadyOut (iReadyOut),
    .dsRdEnOut (dsRdEnOut),
    .dsWrEnOut (dsWrEnOut),
    .dsAdrOut  (dsAdrOut),
    .dsWDataOut(dsWDataOut),
    .dsRDataIn (dsRDataIn),
    .dsReadyIn (dsReadyIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic        rst, d_rd, d_wr;
    logic [31:0] d_adr, d_wd;
    logic        i_rd;
    logic [31:0] i_adr, ds_rdata;
    logic        ds_rdy;
    logic [1:0]  e_st;
    logic        e_ds_rd, e_ds_wr;
    logic [31:0] e_ds_adr, e_ds_wd;
    logic        e_d_rdy, e_i_rdy;
    logic [31:0] e_d_rdata, e_i_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input string nm, input logic r, input logic drd, input logic dwr,
    input logic [31:0] dadr, input logic [31:0] dwd, input logic ird,
    input logic [31:0] iadr, input logic [31:0] dsrd, input logic dsrdy,
    input logic [1:0] est, input logic edsrd, input logic edswr,
    input logic [31:0] edsadr, input logic [31:0] edswd,
    input logic edrdy, input logic eirdy,
    input logic [31:0] edrdata, input logic [31:0] eirdata);
    vec_t v;
    v.name = nm; v.rst = r; v.d_rd = drd; v.d_wr = dwr; v.d_adr = dadr; v.d_wd = dwd;
    v.i_rd = ird; v.i_adr = iadr; v.ds_rdata = dsrd; v.ds_rdy = dsrdy;
    v.e_st = est; v.e_ds_rd = edsrd; v.e_ds_wr = edswr; v.e_ds_adr = edsadr;
    v.e_ds_wd = edswd; v.e_d_rdy = edrdy; v.e_i_rdy = eirdy;
    v.e_d_rdata = edrdata; v.e_i_rdata = eirdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; dRdEnIn = v.d_rd; dWrEnIn = v.d_wr; dAdrIn = v.d_adr;
    dWDataIn = v.d_wd; iRdEnIn = v.i_rd; iAdrIn = v.i_adr;
    dsRDataIn = v.ds_rdata; dsReadyIn = v.ds_rdy;
  endtask

  task automatic check_vec(input vec_t v);
    chk({v.name, ".state"},    32'(dut.r_state), 32'(v.e_st));
    chk({v.name, ".dsRdEn"},   32'(dsRdEnOut),   32'(v.e_ds_rd));
    chk({v.name, ".dsWrEn"},   32'(dsWrEnOut),   32'(v.e_ds_wr));
    chk({v.name, ".dsAdr"},    dsAdrOut,         v.e_ds_adr);
    chk({v.name, ".dsWData"},  dsWDataOut,       v.e_ds_wd);
    chk({v.name, ".dReady"},   32'(dReadyOut),   32'(v.e_d_rdy));
    chk({v.name, ".iReady"},   32'(iReadyOut),   32'(v.e_i_rdy));
    chk({v.name, ".dRData"},   dRDataOut,        v.e_d_rdata);
    chk({v.name, ".iRData"},   iRDataOut,        v.e_i_rdata);
  endtask

  initial begin
    rst = 1'b1; dRdEnIn = 0; dWrEnIn = 0; dAdrIn = '0; dWDataIn = '0;
    iRdEnIn = 0; iAdrIn = '0; dsRDataIn = '0; dsReadyIn = 0;
    #1 rst = 1'b0;

    // name rst dRd dWr dAdr dWd iRd iAdr dsRData dsRdy | st dsRd dsWr dsAdr dsWd dRdy iRdy dRData iRData
    vecs.push_back(mk("rst0", 0,1,0,32'h400,0, 1,32'h100,0,0,  0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk("rst1", 0,1,0,32'h400,0, 1,32'h100,0,0,  0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk("rel",  1,1,0,32'h400,0, 1,32'h100,0,0,  0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk("drd1", 1,1,0,32'h400,0, 0,0,32'hCAFEF00D,0, 1,1,0,32'h400,0, 0,1,32'hCAFEF00D,0));
    vecs.push_back(mk("drd2", 1,1,0,32'h400,0, 0,0,32'hCAFEF00D,0, 1,1,0,32'h400,0, 0,1,32'hCAFEF00D,0));
    vecs.push_back(mk("drd3", 1,1,0,32'h400,0, 0,0,32'hCAFEF00D,1, 1,1,0,32'h400,0, 1,1,32'hCAFEF00D,0));
    vecs.push_back(mk("didle",1,0,0,0,0, 0,0,32'hDEADBEEF,0, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk("cf1_req",1,0,1,32'h8,32'h12345678, 1,32'h100,32'h11111111,1, 0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk("cf1_d",  1,0,1,32'h8,32'h12345678, 1,32'h100,32'h11111111,1,
                      1,0,1,32'h8,32'h12345678, 1,0,32'h11111111,0));
    vecs.push_back(mk("cf2_req",1,0,1,32'hC,32'hA5A5A5A5, 1,32'h100,32'h22222222,1, 0,0,0,0,0, 0,0,0,0));
`ifdef ARB_RR_EN
    vecs.push_back(mk("cf2_win",1,0,1,32'hC,32'hA5A5A5A5, 1,32'h100,32'h22222222,1,
                      2,1,0,32'h100,0, 0,1,0,32'h22222222));
    vecs.push_back(mk("cf2_nxt",1,0,1,32'hC,32'hA5A5A5A5, 0,0,32'h33333333,1, 0,0,0,0,0, 0,1,0,0));
    vecs.push_back(mk("cf2_los",1,0,1,32'hC,32'hA5A5A5A5, 0,0,32'h33333333,1,
                      1,0,1,32'hC,32'hA5A5A5A5, 1,1,32'h33333333,0));
`else
    vecs.push_back(mk("cf2_win",1,0,1,32'hC,32'hA5A5A5A5, 1,32'h100,32'h22222222,1,
                      1,0,1,32'hC,32'hA5A5A5A5, 1,0,32'h22222222,0));
    vecs.push_back(mk("cf2_nxt",1,0,0,0,0, 1,32'h100,32'h33333333,1, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk("cf2_los",1,0,0,0,0, 1,32'h100,32'h33333333,1,
                      2,1,0,32'h100,0, 1,1,0,32'h33333333));
`endif
    vecs.push_back(mk("idle2",  1,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1,0,0));
    vecs.push_back(mk("rw_req", 1,1,1,32'h20,32'h0BADC0DE, 0,0,32'h44444444,0, 0,0,0,0,0, 0,1,0,0));
    vecs.push_back(mk("rw_busy",1,1,1,32'h20,32'h0BADC0DE, 0,0,32'h44444444,0,
                      1,0,1,32'h20,32'h0BADC0DE, 0,1,32'h44444444,0));
    vecs.push_back(mk("rw_done",1,1,1,32'h20,32'h0BADC0DE, 0,0,32'h44444444,1,
                      1,0,1,32'h20,32'h0BADC0DE, 1,1,32'h44444444,0));
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        vecs.push_back(mk($sformatf("strm%0d", k), 1,0,0,0,0, 1,32'h200,32'h55555555,1,
                          0,0,0,0,0, 1,0,0,0));
      else
        vecs.push_back(mk($sformatf("strm%0d", k), 1,0,0,0,0, 1,32'h200,32'h55555555,1,
                          2,1,0,32'h200,0, 1,1,0,32'h55555555));
    end
    vecs.push_back(mk("wd_req", 1,0,0,0,0, 1,32'h240,0,0, 0,0,0,0,0, 1,0,0,0));
    vecs.push_back(mk("wd_drop",1,0,0,0,0, 0,32'h240,32'h66666666,0, 2,0,0,32'h240,0, 1,1,0,32'h66666666));
    vecs.push_back(mk("wd_done",1,0,0,0,0, 0,32'h240,32'h66666666,1, 2,0,0,32'h240,0, 1,1,0,32'h66666666));
    vecs.push_back(mk("wd_idle",1,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,1,0,0));

    foreach (vecs[n]) begin
      @(posedge clk); #1;
      apply(vecs[n]);
      #3;
      check_vec(vecs[n]);
    end

    // Asynchronous reset in the middle of an I access.
    @(posedge clk); #1;
    iRdEnIn = 1'b1; iAdrIn = 32'h300; dsReadyIn = 1'b0; dsRDataIn = 32'h77777777;
    @(posedge clk); #1;
    chk("mid.busy_state", 32'(dut.r_state), 32'd2);
    chk("mid.busy_rden",  32'(dsRdEnOut),   32'd1);
    chk("mid.busy_irdy",  32'(iReadyOut),   32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid.rst_rden",  32'(dsRdEnOut),   32'd0);
    chk("mid.rst_irdy",  32'(iReadyOut),   32'd1);
    chk("mid.rst_state", 32'(dut.r_state), 32'd0);
    chk("mid.rst_adr",   dsAdrOut,         32'h0);
    chk("mid.rst_irdat", iRDataOut,        32'h0);
    @(posedge clk); #1;
    iRdEnIn = 1'b0; rst = 1'b1;
    #3;
    chk("post.state", 32'(dut.r_state), 32'd0);
    chk("post.irdy",  32'(iReadyOut),   32'd1);
    chk("post.drdy",  32'(dReadyOut),   32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cache/SRAM memory port between two requesters: the MEM-stage data port (master D) and the instruction-fetch port (master I).
- Sits between the pipeline stages and the cache controller, which in turn drives the SRAM controller.
- Serialises accesses with a grant FSM and muxes each granted master's request onto the downstream port.
- Produces per-master ready outputs used as pipeline freeze signals.

Parameters:
ADDR_W, 32, address width of both masters and the downstream port
DATA_W, 32, read/write data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
dRdEnIn  in  1  master D read request
dWrEnIn  in  1  master D write request
dAdrIn  in  ADDR_W  master D address
dWDataIn  in  DATA_W  master D write data
dRDataOut  out  DATA_W  master D read data, valid when dReadyOut=1 after a read
dReadyOut  out  1  master D not stalled
iRdEnIn  in  1  master I read request
iAdrIn  in  ADDR_W  master I address
iRDataOut  out  DATA_W  master I read data
iReadyOut  out  1  master I not stalled
dsRdEnOut  out  1  downstream read enable
dsWrEnOut  out  1  downstream write enable
dsAdrOut  out  ADDR_W  downstream address
dsWDataOut  out  DATA_W  downstream write data
dsRDataIn  in  DATA_W  downstream read data
dsReadyIn  in  1  downstream completion; high in the cycle the current access finishes, which may be the first enabled cycle

Behaviour:
- Clock and reset are fixed:
  - clk is the single clock.
  - rst is asynchronous and active-low.
  - While rst=0: state=IDLE, grant cleared, all ds*EnOut=0, dsAdrOut/dsWDataOut=0, dReadyOut=iReadyOut=1, rData outputs 0.
  - Reset asserted mid-access drops the downstream enables immediately (asynchronously); the access is abandoned.
- Requests:
  - reqD = dRdEnIn|dWrEnIn; reqI = iRdEnIn.
  - A master holds its inputs stable while its ready is 0. Inputs are muxed live, not latched.
- FSM states: IDLE, BUSY_D, BUSY_I.
  - IDLE: no downstream enables. If reqD, go to BUSY_D; else if reqI, go to BUSY_I; else stay. D has fixed priority on simultaneous requests.
  - BUSY_x: the downstream port carries master x's signals. On dsReadyIn=1, go to IDLE. Otherwise stay.
  - A completion always returns through IDLE, so a master still asserting its just-completed request is not re-granted in the same cycle.
- Ready per master:
  - ready = ~req | (state==BUSY_x & dsReadyIn). This is combinational.
  - An idle master (no request) is never stalled.
  - A requesting master is stalled in IDLE and in the other master's BUSY state.
- Read data: dRDataOut/iRDataOut = dsRDataIn when the master is granted, else 0.
- Latency:
  - Request at cycle N gives the grant at N+1.
  - Earliest completion is N+1, on a hit.
  - Minimum 2 cycles per access; back-to-back throughput is one access per 2 cycles.
- dRdEnIn and dWrEnIn both high: treated as a write (dsWrEnOut=1, dsRdEnOut=0).
- Request withdrawn while BUSY (protocol violation): the FSM stays BUSY until dsReadyIn, with enables following the live inputs. No recovery beyond that.

Optional Feature:
ARB_RR_EN
- Defined:
  - IDLE with both requests pending grants the master not granted last.
  - A 1-bit lastGrant register is updated on each completion; its reset value is I, so D wins first.
- Undefined: fixed priority D over I; no lastGrant register.

Decomposition:
- Package mem_arb_pkg holds:
  - state typedef: IDLE=2'd0, BUSY_D=2'd1, BUSY_I=2'd2
  - grant constants: GNT_D, GNT_I
- One sub-module, arb_pick: combinational next-grant selector. Inputs reqD, reqI, lastGrant; output pick/valid. It isolates the ARB_RR_EN logic.

Test Plan:
- Reset: rst=0 with both requests high -> ds enables 0, both readies 1. Release rst -> BUSY_D one cycle later.
- Single D read, adr=0x400, dsReadyIn at the 3rd BUSY cycle, dsRDataIn=0xCAFEF00D -> dReadyOut low for 3 cycles, high with dRDataOut=0xCAFEF00D, FSM in IDLE next cycle.
- Simultaneous D write (adr=0x8, data=0x12345678) and I read (adr=0x100), immediate dsReadyIn:
  - Default build: D served first, I stalled 2 cycles, then I served.
  - ARB_RR_EN build: same on the first conflict. On the second conflict I is served first.
- D asserts rdEn and wrEn together -> dsWrEnOut=1, dsRdEnOut=0.
- Reset mid-access: rst falls during BUSY_I with dsReadyIn=0 -> dsRdEnOut=0 in the same cycle (asynchronous), iReadyOut=1, state IDLE.
- I hit streaming: iRdEnIn held with immediate dsReadyIn, masters re-requesting each cycle -> grant alternates BUSY_I/IDLE, iReadyOut pulses every 2nd cycle.
